// File: rtl/adc_serial_responder_if.sv
// adc_serial_responder_if: cs_n/sclk/sdata link between the ADC controller (master) and the emulated ADC (slave)
interface adc_serial_responder_if;
  logic sclk;
  logic cs_n;
  logic sdata;
  logic sdata_oe;
  modport master (output sclk, cs_n, input sdata, sdata_oe);
  modport slave (input sclk, cs_n, output sdata, sdata_oe);
endinterface

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: serial ADC emulator serving test-pattern words over cs_n/sclk/sdata.
// Define ADC_QUIET_CHECK_EN to enable the cs_n inter-frame quiet-time check.
module adc_serial_responder #(
  parameter int DATA_BITS = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int ROW_PIXELS = 112,
  parameter logic [11:0] LFSR_SEED = 12'hACE,
  parameter int QUIET_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  adc_serial_responder_if.slave link,
  input  logic [1:0] pattern_mode,
  input  logic [DATA_BITS-1:0] fixed_value,
  output logic conversion_done,
  output logic framing_error,
  output logic [15:0] sample_count,
  output logic quiet_violation
);
  localparam int F = LEAD_ZEROS + DATA_BITS;
  localparam int CW = $clog2(ROW_PIXELS);
  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, sclk_d, cs_q, cs_d;
  logic [F-1:0] shreg_q, shreg_d;
  logic [4:0] bitcnt_q, bitcnt_d;
  logic done_q, done_d, ferr_q, ferr_d;
  logic [15:0] count_q, count_d;
  logic [DATA_BITS-1:0] ramp_q, ramp_d, pattern;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [11:0] lfsr_q, lfsr_d;
  logic sclk_fall, cs_fall, cs_rise, col_wrap;
  if (LFSR_SEED == '0 || QUIET_CYCLES < 1) $error("LFSR_SEED must be nonzero and QUIET_CYCLES positive");
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sclk_q <= '0;
      cs_q <= '1;
      shreg_q <= '0;
      bitcnt_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      count_q <= '0;
      ramp_q <= '0;
      row_q <= '0;
      col_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      shreg_q <= shreg_d;
      bitcnt_q <= bitcnt_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      count_q <= count_d;
      ramp_q <= ramp_d;
      row_q <= row_d;
      col_q <= col_d;
      lfsr_q <= lfsr_d;
    end
  end
  // [0],[1] synchronize the pins; [2] is history for edge detection
  always_comb begin
    sclk_d = {sclk_q[1:0], link.sclk};
    cs_d = {cs_q[1:0], link.cs_n};
    sclk_fall = sclk_q[2] & ~sclk_q[1];
    cs_fall = cs_q[2] & ~cs_q[1];
    cs_rise = ~cs_q[2] & cs_q[1];
    pattern = pattern_mode == 2'd0 ? fixed_value :
              pattern_mode == 2'd1 ? ramp_q :
              pattern_mode == 2'd2 ? DATA_BITS'({row_q[5:0], col_q[5:0]}) : DATA_BITS'(lfsr_q);
    state_d = state_q;
    shreg_d = shreg_q;
    bitcnt_d = bitcnt_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
    // cs_n rise is tested before sclk fall so it wins a same-cycle collision
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d = SHIFT;
        shreg_d = F'(pattern);
        bitcnt_d = '0;
      end
      SHIFT: if (cs_rise) begin
        state_d = IDLE;
        ferr_d = 1'b1;
        shreg_d = '0;
      end else if (sclk_fall) begin
        shreg_d = shreg_q << 1;
        bitcnt_d = bitcnt_q + 5'd1;
        state_d = bitcnt_q == 5'(F-1) ? TRAIL : SHIFT;
      end
      TRAIL: if (cs_rise) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    col_wrap = done_d && col_q == CW'(ROW_PIXELS-1);
    count_d = count_q + 16'(done_d);
    ramp_d = ramp_q + DATA_BITS'(done_d);
    col_d = col_wrap ? '0 : col_q + CW'(done_d);
    row_d = !col_wrap ? row_q : row_q == CW'(ROW_PIXELS-1) ? '0 : row_q + CW'(1);
    lfsr_d = done_d ? {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]} : lfsr_q;
  end
  // shreg is all zeros outside SHIFT, so sdata idles low without extra gating
  always_comb begin
    link.sdata = shreg_q[F-1];
    link.sdata_oe = state_q != IDLE;
    conversion_done = done_q;
    framing_error = ferr_q;
    sample_count = count_q;
  end
`ifdef ADC_QUIET_CHECK_EN
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic quiet_q, quiet_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_cnt_q <= QW'(QUIET_CYCLES);
      quiet_q <= 1'b0;
    end else begin
      quiet_cnt_q <= quiet_cnt_d;
      quiet_q <= quiet_d;
    end
  end
  always_comb begin
    quiet_cnt_d = !cs_q[1] ? '0 : quiet_cnt_q == QW'(QUIET_CYCLES) ? quiet_cnt_q : quiet_cnt_q + QW'(1);
    quiet_d = cs_fall && state_q == IDLE && quiet_cnt_q < QW'(QUIET_CYCLES);
  end
  assign quiet_violation = quiet_q;
`else
  assign quiet_violation = 1'b0;
`endif
endmodule
